// File: rtl/fsm_send_pkg.sv
// fsm_send_pkg: shared debugger sizes and the
// transmit sequencer state encoding.
package fsm_send_pkg;

  localparam int PIPE_W  = 2592;
  localparam int CNT_W   = 32;
  localparam int N_BYTES = 328;
  localparam int DATA_W  = N_BYTES * 8;
  localparam int IDX_W   = 9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/fsm_send_if.sv
// fsm_send_if: snapshot input and UART TX
// byte handshake seen by the sequencer.
interface fsm_send_if;
  import fsm_send_pkg::*;

  logic [DATA_W-1:0] i_data_from_pipe;
  logic              is_start;
  logic              is_tx_done;
  logic [7:0]        o_tx_data;
  logic              os_tx_start;
  logic              os_done;

  modport master (
    output i_data_from_pipe,
    output is_start,
    output is_tx_done,
    input  o_tx_data,
    input  os_tx_start,
    input  os_done
  );

  modport slave (
    input  i_data_from_pipe,
    input  is_start,
    input  is_tx_done,
    output o_tx_data,
    output os_tx_start,
    output os_done
  );

endinterface

// File: rtl/fsm_send.sv
// fsm_send: latches a pipeline snapshot and feeds
// it byte by byte to the UART transmitter.
module fsm_send
  import fsm_send_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  fsm_send_if.slave bus
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] frame_q, frame_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              done_q, done_d;
  logic              last_byte;

  assign last_byte = (idx_q == IDX_W'(N_BYTES - 1));

  // state, index, frame and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      frame_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      done_q     <= done_d;
    end
  end

  // next state, byte index and frame capture
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    case (state_q)
      S_IDLE: begin
        if (bus.is_start) begin
          frame_d = bus.i_data_from_pipe;
          idx_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.is_tx_done) begin
          if (last_byte) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SEND;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // byte select and strobes, registered one cycle later
  always_comb begin
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    done_d     = 1'b0;
    if (state_q == S_SEND) begin
      tx_data_d  = frame_q[{idx_q, 3'b000} +: 8];
      tx_start_d = 1'b1;
    end
    if (state_q == S_DONE) begin
      done_d = 1'b1;
    end
  end

  assign bus.o_tx_data   = tx_data_q;
  assign bus.os_tx_start = tx_start_q;
  assign bus.os_done     = done_q;

endmodule

// File: tb/tb_fsm_send.sv
// tb_fsm_send: vector table for reset/first byte,
// scoreboard for every transmitted byte.
module tb_fsm_send;
  import fsm_send_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fsm_send_if bus();

  fsm_send dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rst;
    logic       start;
    logic       txd;
    logic [7:0] data;
    logic       st;
    logic       dn;
  } vec_t;

  int total = 0;
  int bad = 0;
  int strobe_cnt = 0;
  int done_cnt = 0;
  bit busy = 0;
  logic [7:0] exp_q[$];
  logic [DATA_W-1:0] fa, fb, alt;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] tmp;
    for (int i = 0; i < N_BYTES; i++) begin
      tmp = d >> (8 * i);
      exp_q.push_back(tmp[7:0]);
    end
  endtask

  // scoreboard: pop expected byte on each strobe
  always @(negedge clk) begin
    if (bus.os_tx_start === 1'b1) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        chk("tx_byte", {24'd0, bus.o_tx_data},
            {24'd0, exp_q.pop_front()});
      end
      chk("strobe_and_done", {31'd0, bus.os_done}, 32'd0);
    end
    if (bus.os_done === 1'b1) begin
      done_cnt++;
      chk("done_queue_empty", exp_q.size(), 32'd0);
      busy = 0;
    end
  end

  task automatic start_frame(input logic [DATA_W-1:0] d);
    bus.i_data_from_pipe = d;
    push_frame(d);
    busy = 1;
    strobe_cnt = 0;
    done_cnt = 0;
    bus.is_start = 1'b1;
    @(posedge clk); #1;
    bus.is_start = 1'b0;
  endtask

  task automatic serve(input int n, input bit check_end,
                       input int inject_at);
    int polls;
    for (int i = 0; i < n; i++) begin
      polls = 0;
      do begin
        @(posedge clk); #1;
        polls++;
      end while (!bus.os_tx_start && polls < 50);
      if (!bus.os_tx_start) begin
        chk("strobe_timeout", 32'd0, 32'd1);
        return;
      end
      chk("strobe_latency", polls, 32'd1);
      if (i == inject_at) begin
        bus.is_start = 1'b1;
        bus.i_data_from_pipe = alt;
      end
      repeat (4) begin
        @(posedge clk); #1;
        bus.is_start = 1'b0;
      end
      bus.is_tx_done = 1'b1;
      @(posedge clk); #1;
      bus.is_tx_done = 1'b0;
      if (check_end && i == n - 1) begin
        chk("done_early", {31'd0, bus.os_done}, 32'd0);
        @(posedge clk); #1;
        chk("done_pulse", {31'd0, bus.os_done}, 32'd1);
        @(posedge clk); #1;
        chk("done_width", {31'd0, bus.os_done}, 32'd0);
      end
    end
  endtask

  vec_t tbl[9];

  initial begin
    fa = '0;
    fa[0] = 1'b1;
    fa[PIPE_W-1] = 1'b1;
    fa[DATA_W-1 -: CNT_W] = 32'hFFFF_FFFF;
    alt = ~fa;
    fb = '0;
    for (int w = 0; w < DATA_W / 32; w++) begin
      fb[w*32 +: 32] = $urandom;
    end

    tbl[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0};

    bus.i_data_from_pipe = fa;
    bus.is_start = 1'b0;
    bus.is_tx_done = 1'b0;

    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst;
      bus.is_start = tbl[i].start;
      bus.is_tx_done = tbl[i].txd;
      if (tbl[i].start && tbl[i].rst && !busy) begin
        push_frame(fa);
        busy = 1;
      end
      @(posedge clk); #1;
      chk($sformatf("vec%0d_data", i),
          {24'd0, bus.o_tx_data}, {24'd0, tbl[i].data});
      chk($sformatf("vec%0d_start", i),
          {31'd0, bus.os_tx_start}, {31'd0, tbl[i].st});
      chk($sformatf("vec%0d_done", i),
          {31'd0, bus.os_done}, {31'd0, tbl[i].dn});
    end
    bus.is_start = 1'b0;
    bus.is_tx_done = 1'b0;
    strobe_cnt = 1;
    done_cnt = 0;

    repeat (100) begin
      @(posedge clk); #1;
      chk("stall_data", {24'd0, bus.o_tx_data}, 32'h01);
      chk("stall_strobe", {31'd0, bus.os_tx_start}, 32'd0);
    end
    bus.is_tx_done = 1'b1;
    @(posedge clk); #1;
    bus.is_tx_done = 1'b0;

    serve(N_BYTES - 1, 1'b1, 20);
    @(posedge clk); #1;
    chk("frameA_strobes", strobe_cnt, N_BYTES);
    chk("frameA_dones", done_cnt, 32'd1);
    chk("frameA_queue", exp_q.size(), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    start_frame(fb);
    serve(4, 1'b0, -1);
    rst = 1'b0;
    exp_q.delete();
    busy = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", {24'd0, bus.o_tx_data}, 32'h00);
    chk("rst_strobe", {31'd0, bus.os_tx_start}, 32'd0);
    chk("rst_done", {31'd0, bus.os_done}, 32'd0);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_strobes", strobe_cnt, 32'd4);
    chk("abort_no_done", done_cnt, 32'd0);

    start_frame(fb);
    serve(N_BYTES, 1'b1, -1);
    @(posedge clk); #1;
    chk("frameB_strobes", strobe_cnt, N_BYTES);
    chk("frameB_dones", done_cnt, 32'd1);
    chk("frameB_queue", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
